// File: rtl/unit_sram_dp_banked.sv
// Banked dual-port SRAM tile: one write port and one read port, run-time element width
// (1..32 bits), optional registered output, write-first / collision-flagged same-row access.
// Each bank's storage is a behavioural stand-in for one 32x512 1rw1r macro. Controls are
// registered on the accepting edge, and the array is accessed on the following edge.
module unit_sram_dp_banked #(
    parameter  int unsigned NUM_BANKS = 2,
    localparam int unsigned BANK_BITS = $clog2(NUM_BANKS),
    localparam int unsigned ABW       = 14 + BANK_BITS
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [31:0]    d_fabric_in,
    input  logic           csb,
    input  logic           web,
    input  logic           reb,
    input  logic [ABW-1:0] addr_w,
    input  logic [ABW-1:0] addr_r,
    input  logic [2:0]     conf,
    input  logic           out_reg,
    output logic [31:0]    d_fabric_out,
    output logic           rd_valid,
    output logic           rd_collision
);
    // Bank registers need at least one bit even for a single bank.
    localparam int unsigned   BW        = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam logic [BW-1:0] BANK_MASK = BW'(NUM_BANKS - 1);

    function automatic logic [2:0] clamp_conf(input logic [2:0] c);
        return (c > 3'd5) ? 3'd5 : c;
    endfunction

    // W ones in the low bits, W = 2^cc.
    function automatic logic [31:0] elem_ones(input logic [2:0] cc);
        return 32'hFFFF_FFFF >> (6'd32 - (6'd1 << cc));
    endfunction

    // Split an element address into row, bank and lane; higher bits alias.
    function automatic void decode(input logic [ABW-1:0] a, input logic [2:0] cc,
                                   output logic [8:0] row, output logic [BW-1:0] bank,
                                   output logic [4:0] lane);
        logic [2:0]     k;
        logic [ABW-1:0] sh;
        logic [4:0]     lmask;
        k     = 3'd5 - cc;
        sh    = a >> k;
        row   = sh[8:0];
        bank  = BW'(sh >> 9) & BANK_MASK;
        lmask = ~(5'h1F << k);
        lane  = a[4:0] & lmask;
    endfunction

    logic [2:0]    cc;
    logic [8:0]    w_row, r_row;
    logic [BW-1:0] w_bank, r_bank;
    logic [4:0]    w_lane, r_lane, rep_mask;
    logic [31:0]   w_ones, w_elem, w_mask, w_din;
    logic          w_acc, r_acc, row_hit, same_elem;

    // Decode both ports and build the write mask and replicated write data.
    always_comb begin
        cc = clamp_conf(conf);
        decode(addr_w, cc, w_row, w_bank, w_lane);
        decode(addr_r, cc, r_row, r_bank, r_lane);
        w_ones   = elem_ones(cc);
        w_elem   = d_fabric_in & w_ones;
        w_mask   = w_ones << (w_lane << cc);
        rep_mask = ~(5'h1F << cc);
        w_din    = '0;
        for (int i = 0; i < 32; i++) begin
            w_din[i] = d_fabric_in[5'(i) & rep_mask];
        end
        w_acc     = !csb && !web;
        r_acc     = !csb && !reb;
        row_hit   = w_acc && r_acc && (w_bank == r_bank) && (w_row == r_row);
        same_elem = row_hit && (w_lane == r_lane);
    end

    logic [NUM_BANKS-1:0] w_csb_q, w_web_q, r_csb_q;
    logic [8:0]           w_row_q, r_row_q;
    logic [31:0]          w_mask_q, w_din_q, r_welem_q;
    logic                 r_valid_q, r_oreg_q, r_same_q, r_diff_q;
    logic [BW-1:0]        r_bank_q;
    logic [4:0]           r_lane_q;
    logic [2:0]           r_cc_q;

    // Acceptance stage: per-bank macro controls plus the read's lane/width context.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_csb_q   <= '1;
            w_web_q   <= '1;
            r_csb_q   <= '1;
            w_row_q   <= '0;
            w_mask_q  <= '0;
            w_din_q   <= '0;
            r_valid_q <= 1'b0;
            r_row_q   <= '0;
            r_bank_q  <= '0;
            r_lane_q  <= '0;
            r_cc_q    <= '0;
            r_oreg_q  <= 1'b0;
            r_same_q  <= 1'b0;
            r_diff_q  <= 1'b0;
            r_welem_q <= '0;
        end else begin
            for (int b = 0; b < int'(NUM_BANKS); b++) begin
                w_csb_q[b] <= !(w_acc && (w_bank == BW'(b)));
                w_web_q[b] <= !(w_acc && (w_bank == BW'(b)));
                r_csb_q[b] <= !(r_acc && (r_bank == BW'(b)));
            end
            r_valid_q <= r_acc;
            if (w_acc) begin
                w_row_q  <= w_row;
                w_mask_q <= w_mask;
                w_din_q  <= w_din;
            end
            if (r_acc) begin
                r_row_q   <= r_row;
                r_bank_q  <= r_bank;
                r_lane_q  <= r_lane;
                r_cc_q    <= cc;
                r_oreg_q  <= out_reg;
                r_same_q  <= same_elem;
                r_diff_q  <= row_hit && !same_elem;
                r_welem_q <= w_elem;
            end
        end
    end

    logic [NUM_BANKS-1:0][31:0] bank_dout;

    for (genvar b = 0; b < int'(NUM_BANKS); b++) begin : g_bank
        logic [31:0] mem [512];
        logic [31:0] dout_q;
        // Macro model: port 0 bit-masked write, port 1 read; contents survive reset.
        always_ff @(posedge clk) begin
            if (!w_csb_q[b] && !w_web_q[b]) begin
                mem[w_row_q] <= (mem[w_row_q] & ~w_mask_q) | (w_din_q & w_mask_q);
            end
            if (!r_csb_q[b]) begin
                dout_q <= mem[r_row_q];
            end
        end
        assign bank_dout[b] = dout_q;
    end

    logic          s1_valid_q, s1_oreg_q, s1_same_q, s1_diff_q;
    logic [BW-1:0] s1_bank_q;
    logic [4:0]    s1_lane_q;
    logic [2:0]    s1_cc_q;
    logic [31:0]   s1_welem_q;

    // Context of the read whose macro data is on dout1 this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_oreg_q  <= 1'b0;
            s1_same_q  <= 1'b0;
            s1_diff_q  <= 1'b0;
            s1_bank_q  <= '0;
            s1_lane_q  <= '0;
            s1_cc_q    <= '0;
            s1_welem_q <= '0;
        end else begin
            s1_valid_q <= r_valid_q;
            if (r_valid_q) begin
                s1_oreg_q  <= r_oreg_q;
                s1_same_q  <= r_same_q;
                s1_diff_q  <= r_diff_q;
                s1_bank_q  <= r_bank_q;
                s1_lane_q  <= r_lane_q;
                s1_cc_q    <= r_cc_q;
                s1_welem_q <= r_welem_q;
            end
        end
    end

    logic [31:0] raw, s1_data;

    // Lane extraction from the selected bank, overridden on collisions.
    always_comb begin
        raw = '0;
        for (int b = 0; b < int'(NUM_BANKS); b++) begin
            if (s1_bank_q == BW'(b)) begin
                raw = bank_dout[b];
            end
        end
        if (s1_same_q) begin
            s1_data = s1_welem_q;
        end else if (s1_diff_q) begin
            s1_data = '0;
        end else begin
            s1_data = (raw >> (s1_lane_q << s1_cc_q)) & elem_ones(s1_cc_q);
        end
    end

    logic        s2_valid_q, s2_coll_q;
    logic [31:0] s2_data_q;

    // Optional output register stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_coll_q  <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            s2_valid_q <= s1_valid_q && s1_oreg_q;
            s2_coll_q  <= s1_diff_q;
            s2_data_q  <= s1_data;
        end
    end

    // Registered read wins over an unregistered one landing in the same cycle.
    always_comb begin
        d_fabric_out = '0;
        rd_valid     = 1'b0;
        rd_collision = 1'b0;
        if (s2_valid_q) begin
            d_fabric_out = s2_data_q;
            rd_valid     = 1'b1;
            rd_collision = s2_coll_q;
        end else if (s1_valid_q && !s1_oreg_q) begin
            d_fabric_out = s1_data;
            rd_valid     = 1'b1;
            rd_collision = s1_diff_q;
        end
    end

endmodule

// File: tb/tb_unit_sram_dp_banked.sv
// Bench for unit_sram_dp_banked: directed scenarios plus random traffic, all checked
// against a flat bit-addressed memory model with a per-cycle expected-output schedule.
module tb_unit_sram_dp_banked;
    localparam int NB   = 2;
    localparam int ABW  = 15;
    localparam int BITS = NB * 16384;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] d_fabric_in = '0;
    logic        csb = 1'b1, web = 1'b1, reb = 1'b1;
    logic [ABW-1:0] addr_w = '0, addr_r = '0;
    logic [2:0]  conf = '0;
    logic        out_reg = 1'b0;
    logic [31:0] d_fabric_out;
    logic        rd_valid, rd_collision;

    always #5 clk = ~clk;

    unit_sram_dp_banked #(.NUM_BANKS(NB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .d_fabric_in  (d_fabric_in),
        .csb          (csb),
        .web          (web),
        .reb          (reb),
        .addr_w       (addr_w),
        .addr_r       (addr_r),
        .conf         (conf),
        .out_reg      (out_reg),
        .d_fabric_out (d_fabric_out),
        .rd_valid     (rd_valid),
        .rd_collision (rd_collision)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model state: memory as one flat bit array; element A at width W starts at bit A*W.
    bit          mem_bits [BITS];
    bit          pend_v = 1'b0;
    int          pend_ba, pend_w;
    logic [31:0] pend_d;
    bit          exp_v [int];
    logic [31:0] exp_d [int];
    bit          exp_c [int];
    logic [31:0] obs_d;
    logic        obs_v, obs_c;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic int width_of(input int cf);
        return 1 << ((cf > 5) ? 5 : cf);
    endfunction

    function automatic int bit_addr(input int a, input int cf);
        return (a * width_of(cf)) % BITS;
    endfunction

    // Writes land one edge after acceptance; reads see every earlier-accepted write.
    task automatic model_accept(input bit we, input int wa, input logic [31:0] wd,
                                input bit re, input int ra, input int cf, input bit orr);
        int w, wba, rba, slot;
        logic [31:0] val;
        bit col;
        if (pend_v) begin
            for (int j = 0; j < pend_w; j++) mem_bits[pend_ba + j] = pend_d[j];
            pend_v = 1'b0;
        end
        w   = width_of(cf);
        wba = bit_addr(wa, cf);
        if (re) begin
            rba = bit_addr(ra, cf);
            val = '0;
            col = 1'b0;
            if (we && (wba / 32 == rba / 32)) begin
                if (wba == rba) begin
                    for (int j = 0; j < w; j++) val[j] = wd[j];
                end else begin
                    col = 1'b1;
                end
            end else begin
                for (int j = 0; j < w; j++) val[j] = mem_bits[rba + j];
            end
            slot = cyc + (orr ? 2 : 1);
            if (!exp_v.exists(slot)) begin
                exp_v[slot] = 1'b1;
                exp_d[slot] = val;
                exp_c[slot] = col;
            end
        end
        if (we) begin
            pend_v  = 1'b1;
            pend_ba = wba;
            pend_w  = w;
            pend_d  = wd;
        end
    endtask

    // One clock: drive, let the edge accept, then compare outputs at the falling edge.
    task automatic tick(input bit we, input int wa, input logic [31:0] wd,
                        input bit re, input int ra, input int cf, input bit orr);
        bit          ev, ec;
        logic [31:0] ed;
        web         = ~we;
        reb         = ~re;
        csb         = ~(we | re);
        addr_w      = ABW'(wa);
        addr_r      = ABW'(ra);
        d_fabric_in = wd;
        conf        = 3'(cf);
        out_reg     = orr;
        @(posedge clk);
        cyc++;
        if (rst_n) model_accept(we, wa, wd, re, ra, cf, orr);
        @(negedge clk);
        ev = exp_v.exists(cyc);
        ed = ev ? exp_d[cyc] : 32'h0;
        ec = ev ? exp_c[cyc] : 1'b0;
        if (ev) begin
            exp_v.delete(cyc);
            exp_d.delete(cyc);
            exp_c.delete(cyc);
        end
        check_eq("rd_valid", 32'(rd_valid), 32'(ev));
        check_eq("d_fabric_out", d_fabric_out, ed);
        check_eq("rd_collision", 32'(rd_collision), 32'(ec));
        obs_v = rd_valid;
        obs_d = d_fabric_out;
        obs_c = rd_collision;
    endtask

    task automatic idle();
        tick(1'b0, 0, 32'h0, 1'b0, 0, 5, 1'b0);
    endtask

    task automatic wr(input int a, input logic [31:0] d, input int cf);
        tick(1'b1, a, d, 1'b0, 0, cf, 1'b0);
    endtask

    task automatic rd(input int a, input int cf, input bit orr);
        tick(1'b0, 0, 32'h0, 1'b1, a, cf, orr);
    endtask

    // Asynchronous reset between edges: drops in-flight work, keeps the array.
    task automatic do_reset();
        rst_n = 1'b0;
        pend_v = 1'b0;
        exp_v.delete();
        exp_d.delete();
        exp_c.delete();
        idle();
        idle();
        rst_n = 1'b1;
    endtask

    // Random element address within rows 0..3 of any bank, with random alias bits on top.
    function automatic int rand_addr(input int cf);
        int w, ba;
        w  = width_of(cf);
        ba = (int'($urandom_range(0, NB - 1)) * 512 + int'($urandom_range(0, 3))) * 32
             + int'($urandom_range(0, 32 / w - 1)) * w;
        return ba / w + int'($urandom_range(0, w - 1)) * (BITS / w);
    endfunction

    initial begin
        int vcount;
        @(negedge clk);
        idle();
        idle();
        rst_n = 1'b1;

        // Known contents for rows 0..15 of every bank.
        for (int b = 0; b < NB; b++)
            for (int r = 0; r < 16; r++) wr(b * 512 + r, 32'h0, 5);
        idle();

        // Full-word write to bank 1, read back; bank 0 untouched.
        wr(32'h200, 32'hDEAD_BEEF, 5);
        rd(32'h200, 5, 1'b0);
        idle();
        check_eq("bank1_word", obs_d, 32'hDEAD_BEEF);
        check_eq("bank1_valid", 32'(obs_v), 32'h1);
        rd(32'h000, 5, 1'b0);
        idle();
        check_eq("bank0_word", obs_d, 32'h0);

        // Byte mode, unregistered then registered output.
        wr(6, 32'hA5, 3);
        for (int a = 4; a < 8; a++) begin
            rd(a, 3, 1'b0);
            if (a == 7) check_eq("byte_lane6", obs_d, 32'hA5);
        end
        for (int a = 4; a < 8; a++) rd(a, 3, 1'b1);
        idle();
        check_eq("byte_lane6_reg", obs_d, 32'hA5);
        idle();

        // Bit mode fills a whole word one bit at a time.
        for (int i = 0; i < 32; i++) wr(160 + i, 32'h1, 0);
        idle();
        rd(5, 5, 1'b0);
        idle();
        check_eq("bitfill_word", obs_d, 32'hFFFF_FFFF);

        // Same-cycle write and read: same element, then same row different lane.
        tick(1'b1, 20, 32'h1234, 1'b1, 20, 4, 1'b0);
        idle();
        check_eq("coll_same_data", obs_d, 32'h1234);
        check_eq("coll_same_flag", 32'(obs_c), 32'h0);
        tick(1'b1, 20, 32'h5678, 1'b1, 21, 4, 1'b0);
        idle();
        check_eq("coll_diff_data", obs_d, 32'h0);
        check_eq("coll_diff_flag", 32'(obs_c), 32'h1);

        // Sixteen back-to-back reads alternating banks.
        vcount = 0;
        for (int i = 0; i < 16; i++) begin
            rd((i % 2) * 512 + (i / 2), 5, 1'b0);
            if (i > 0 && obs_v) vcount++;
        end
        idle();
        if (obs_v) vcount++;
        check_eq("b2b_valid_count", 32'(vcount), 32'd16);

        // Reset between acceptance and macro access drops the write and the read.
        wr(32'h201, 32'hCAFE_F00D, 5);
        idle();
        tick(1'b1, 32'h201, 32'h1234_5678, 1'b1, 32'h201, 5, 1'b0);
        do_reset();
        rd(32'h201, 5, 1'b0);
        idle();
        check_eq("reset_preserved", obs_d, 32'hCAFE_F00D);

        // Random traffic with occasional asynchronous resets.
        for (int n = 0; n < 3000; n++) begin
            int cf;
            cf = int'($urandom_range(0, 7));
            tick(1'($urandom_range(0, 1)), rand_addr(cf), $urandom,
                 1'($urandom_range(0, 1)), rand_addr(cf), cf,
                 1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 499) == 0) do_reset();
        end
        idle();
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/unit_sram_dp_banked.md
# unit_sram_dp_banked

Parametrised dual-port SRAM tile for the FPGA fabric, built from NUM_BANKS sky130_sram_2kbyte_1rw1r_32x512_1 macros (32 x 512 each).
- Presents one write port and one read port to the fabric, with run-time aspect ratio (1 to 32 bits per element) and optional output register.
- Adds three behaviours over the single-macro tile: bank selection, deterministic write/read collision handling, and a read-valid strobe.

## Interface
Parameters:
- NUM_BANKS, 2: number of macros; legal values 1, 2, 4.
- BANK_BITS, log2(NUM_BANKS): derived, not overridable.
- ABW, 14+BANK_BITS: element address width.

Ports:
- clk  in  1  single clock; also drives clk0/clk1 of every macro.
- rst_n  in  1  asynchronous, active-low reset.
- d_fabric_in  in  32  write data; the element is in bits [W-1:0].
- csb  in  1  active-low chip select; gates both ports.
- web  in  1  active-low write enable.
- reb  in  1  active-low read enable.
- addr_w  in  ABW  write element address.
- addr_r  in  ABW  read element address.
- conf  in  3  width mode: W = 2^conf for conf 0..5; 6 and 7 behave as 5.
- out_reg  in  1  1 = registered output stage.
- d_fabric_out  out  32  read element, zero-extended in [W-1:0].
- rd_valid  out  1  d_fabric_out holds a completed read this cycle.
- rd_collision  out  1  the read on d_fabric_out collided with a same-row write.

## Operation
- Address decode, with k = 5-min(conf,5):
  - lane = A[k-1:0], or 0 when k=0.
  - row = A[k+8:k].
  - bank = A[k+8+BANK_BITS:k+9].
  - Address bits above k+9+BANK_BITS are ignored (aliasing).
- Write, when csb=0 and web=0 at edge T0:
  - Register row, bank, the wmask of W ones at bit lane*W, and din (element replicated 32/W times).
  - At T1, only the selected bank's csb0/web0 are low.
  - All other banks keep csb0=1.
  - Macro dout0 is unconnected.
- Read, when csb=0 and reb=0 at edge T0:
  - Register row, bank, lane, conf and out_reg.
  - At T1, only the selected bank's csb1 is low.
  - Lane extraction uses the registered conf and lane, never the live inputs.
- Read and write may be requested in the same cycle and are independent, except for collisions.
- Collision: read and write are both accepted at T0 with the same bank and row.
  - Same element: return the write element (write-first) with rd_collision=0.
  - Different element: return 0 with rd_collision=1.
  - The macro read result is discarded in both cases.
- Output path:
  - out_reg=0: d_fabric_out is the combinational lane mux of the selected bank's dout1.
  - out_reg=1: the same value, captured in a 32-bit register.
  - d_fabric_out is 0 whenever rd_valid=0.
- conf and out_reg may change every cycle. Each access uses the values sampled with that access.

## Timing
- Write data is in the array after T1. A read accepted at T1 or later returns it.
- Read accepted at T0:
  - out_reg=0: rd_valid=1 and data valid in the cycle T1..T2.
  - out_reg=1: rd_valid=1 and data valid in the cycle T2..T3.
- Throughput is one read and one write per cycle.
- Mixed out_reg on back-to-back reads (read A with out_reg=1 at T0, read B with out_reg=0 at T1): both present in T2..T3.
  - The registered read A wins.
  - Read B is dropped, with rd_valid reflecting A only.
  - Mixing modes on back-to-back reads is not supported by the fabric mapper.
- Reset, asynchronous assert:
  - All macro csb0/csb1/web0 go to 1.
  - Pipeline valid bits go to 0.
  - The output register, d_fabric_out, rd_valid and rd_collision go to 0.
  - In-flight accesses are dropped; no macro access occurs at the next edge.
  - Array contents are undefined after power-up and preserved across reset.
- Reset release: first access accepted at the first rising edge with rst_n=1.

## Test plan
- conf=5, NUM_BANKS=2: write 0xDEADBEEF at addr 0x200 (bank 1, row 0), then read addr 0x200 with out_reg=0 -> rd_valid and 0xDEADBEEF at T1..T2. Read addr 0x000 -> bank 0 data, with no corruption from the bank 1 write.
- conf=3: write 0xA5 to addr 0x06, then read addr 0x04..0x07 -> 0 for unwritten lanes and 0x000000A5 at addr 6. Repeat with out_reg=1 -> the same values one cycle later.
- conf=0: write 1 to 32 consecutive bit addresses, then read back at conf=5 -> 0xFFFFFFFF. Proves wmask and lane mapping.
- Same-cycle write and read, same element, conf=4, data 0x1234 -> out 0x00001234 and rd_collision=0. Same row, different lane -> out 0 and rd_collision=1.
- Back-to-back reads on every cycle for 16 cycles, alternating banks -> 16 consecutive rd_valid pulses, in order, correct data.
- Assert rst_n low between T0 and T1 of a read and a write -> no macro csb low at T1, rd_valid stays 0, outputs 0. A subsequent read of the target address returns its pre-reset value.
